write_pointer_full: RTL and testbench

- Write-side pointer and full-flag stage of the asynchronous FIFO, clocked by clock_write.
- Consumes the 2-flop-synchronized gray read pointer (sync_read_pointer) and drives the RAM write address and write enable.
- Produces the gray write pointer sent to the read-domain synchronizer, plus registered full, almost_full, level and overflow status.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/write_pointer_full_if.sv | 28 ++
 rtl/write_pointer_full_gray2bin_conv.sv | 14 +
 rtl/write_pointer_full.sv | 80 ++++++++
 tb/tb_write_pointer_full.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO constants and gray/binary pointer helpers, used by both
// the write-side full stage and the read-side empty stage.
package fifo_pkg;

  localparam int ADDR_WIDTH            = 6;
  localparam int PTR_WIDTH             = ADDR_WIDTH + 1;
  localparam int FIFO_DEPTH            = 2 ** ADDR_WIDTH;
  localparam int ALMOST_FULL_THRESHOLD = 4;

  function automatic logic [PTR_WIDTH-1:0] bin2gray(input logic [PTR_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] gray);
    logic [PTR_WIDTH-1:0] bin;
    bin[PTR_WIDTH-1] = gray[PTR_WIDTH-1];
    for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/write_pointer_full_if.sv
// Producer-side bus of the write pointer/full stage: request and synchronized
// read pointer in, RAM strobe/address, gray pointer and status out.
interface write_pointer_full_if;
  import fifo_pkg::*;

  logic                  write_request;
  logic [PTR_WIDTH-1:0]  sync_read_pointer;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [PTR_WIDTH-1:0]  write_pointer;
  logic                  full;
  logic                  almost_full;
  logic [PTR_WIDTH-1:0]  write_level;
  logic                  overflow_error;

  modport master (
    output write_request, sync_read_pointer,
    input  write_enable, write_address, write_pointer, full, almost_full,
           write_level, overflow_error
  );

  modport slave (
    input  write_request, sync_read_pointer,
    output write_enable, write_address, write_pointer, full, almost_full,
           write_level, overflow_error
  );

endinterface

// File: rtl/write_pointer_full_gray2bin_conv.sv
// Parameterised combinational gray-to-binary converter: each binary bit is the
// XOR of all gray bits from the MSB down to that position.
module gray2bin_conv #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/write_pointer_full.sv
// Write-domain pointer, full/almost-full, occupancy and sticky overflow status
// for the asynchronous FIFO.
module write_pointer_full
  import fifo_pkg::*;
(
  input  logic                clock_write,
  input  logic                write_reset,
  write_pointer_full_if.slave bus
);

  localparam logic [PTR_WIDTH-1:0] ALMOST_FULL_LEVEL =
    PTR_WIDTH'(FIFO_DEPTH - ALMOST_FULL_THRESHOLD);

  logic [PTR_WIDTH-1:0]  wbin_q, wbin_d;
  logic [PTR_WIDTH-1:0]  wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [PTR_WIDTH-1:0]  level_q, level_d;
  logic                  full_q, full_d;
  logic                  almost_full_q, almost_full_d;
  logic                  overflow_q, overflow_d;
  logic                  write_enable_s;
  logic [PTR_WIDTH-1:0]  rbin_s;
  logic [PTR_WIDTH-1:0]  full_match_s;

  gray2bin_conv #(.WIDTH(PTR_WIDTH)) u_rptr_conv (
    .gray (bus.sync_read_pointer),
    .bin  (rbin_s)
  );

  // A full FIFO has the write pointer one lap ahead: in gray code that is the
  // top two bits inverted relative to the read pointer.
  assign full_match_s = {~bus.sync_read_pointer[PTR_WIDTH-1:PTR_WIDTH-2],
                         bus.sync_read_pointer[PTR_WIDTH-3:0]};

  assign write_enable_s = bus.write_request & ~full_q & ~write_reset;

  always_comb begin
    wbin_d        = wbin_q + {{(PTR_WIDTH-1){1'b0}}, write_enable_s};
    wptr_d        = bin2gray(wbin_d);
    waddr_d       = wbin_d[ADDR_WIDTH-1:0];
    full_d        = (wptr_d == full_match_s);
    level_d       = wbin_d - rbin_s;
    almost_full_d = (level_d >= ALMOST_FULL_LEVEL);
    overflow_d    = overflow_q;
    if (bus.write_request && full_q) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clock_write or posedge write_reset) begin
    if (write_reset) begin
      wbin_q        <= {PTR_WIDTH{1'b0}};
      wptr_q        <= {PTR_WIDTH{1'b0}};
      waddr_q       <= {ADDR_WIDTH{1'b0}};
      level_q       <= {PTR_WIDTH{1'b0}};
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wbin_q        <= wbin_d;
      wptr_q        <= wptr_d;
      waddr_q       <= waddr_d;
      level_q       <= level_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.write_enable   = write_enable_s;
  assign bus.write_address  = waddr_q;
  assign bus.write_pointer  = wptr_q;
  assign bus.full           = full_q;
  assign bus.almost_full    = almost_full_q;
  assign bus.write_level    = level_q;
  assign bus.overflow_error = overflow_q;

endmodule

// File: tb/tb_write_pointer_full.sv
// Directed self-checking bench for write_pointer_full: reset, fill, overflow,
// drain, pointer wrap and simultaneous write/read-advance scenarios.
module tb_write_pointer_full;

  logic clock_write = 1'b0;
  logic write_reset = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  logic [6:0] wcount;

  write_pointer_full_if bus ();

  write_pointer_full dut (
    .clock_write (clock_write),
    .write_reset (write_reset),
    .bus         (bus.slave)
  );

  always #5 clock_write = ~clock_write;

  function automatic logic [6:0] g(input logic [6:0] b);
    return b ^ {1'b0, b[6:1]};
  endfunction

  task automatic tick();
    @(posedge clock_write);
    #1;
  endtask

  task automatic test_reset();
    bus.write_request     = 1'b0;
    bus.sync_read_pointer = 7'd0;
    #1;
    checks++;
    if (bus.write_pointer !== 7'd0 || bus.full !== 1'b0 || bus.write_level !== 7'd0 ||
        bus.overflow_error !== 1'b0 || bus.write_address !== 6'd0 || bus.almost_full !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: ptr=%b full=%b lvl=%0d ovf=%b addr=%0d af=%b, required all 0",
               bus.write_pointer, bus.full, bus.write_level, bus.overflow_error,
               bus.write_address, bus.almost_full);
    end
    tick();
    tick();
    write_reset = 1'b0;
    bus.write_request = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (bus.write_address !== 6'd20 || bus.write_level !== 7'd20 || bus.write_pointer !== g(7'd20)) begin
      fails++;
      $display("FAIL pre_reset_count: addr=%0d lvl=%0d ptr=%b, required 20 20 %b",
               bus.write_address, bus.write_level, bus.write_pointer, g(7'd20));
    end
    write_reset = 1'b1;
    #1;
    checks++;
    if (bus.write_pointer !== 7'd0 || bus.write_address !== 6'd0 || bus.write_level !== 7'd0 ||
        bus.full !== 1'b0 || bus.write_enable !== 1'b0) begin
      fails++;
      $display("FAIL midstream_reset: ptr=%b addr=%0d lvl=%0d full=%b we=%b, required 0",
               bus.write_pointer, bus.write_address, bus.write_level, bus.full, bus.write_enable);
    end
    #2;
    write_reset = 1'b0;
    #1;
    checks++;
    if (bus.write_enable !== 1'b1 || bus.write_address !== 6'd0) begin
      fails++;
      $display("FAIL post_reset_write: we=%b addr=%0d, required 1 0", bus.write_enable, bus.write_address);
    end
    tick();
    checks++;
    if (bus.write_address !== 6'd1 || bus.write_level !== 7'd1) begin
      fails++;
      $display("FAIL post_reset_first: addr=%0d lvl=%0d, required 1 1", bus.write_address, bus.write_level);
    end
    bus.write_request = 1'b0;
    write_reset = 1'b1;
    #1;
    write_reset = 1'b0;
  endtask

  task automatic test_fill();
    bus.sync_read_pointer = 7'd0;
    bus.write_request     = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      tick();
      checks++;
      if (bus.write_level !== 7'(k) || bus.almost_full !== (k >= 60) || bus.full !== (k == 64)) begin
        fails++;
        $display("FAIL fill_step%0d: lvl=%0d af=%b full=%b, required %0d %b %b",
                 k, bus.write_level, bus.almost_full, bus.full, k, (k >= 60), (k == 64));
      end
    end
    checks++;
    if (bus.write_pointer !== 7'b1100000 || bus.write_address !== 6'd0) begin
      fails++;
      $display("FAIL fill_end: ptr=%b addr=%0d, required 1100000 0", bus.write_pointer, bus.write_address);
    end
  endtask

  task automatic test_overflow();
    bus.write_request = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.write_enable !== 1'b0) begin
        fails++;
        $display("FAIL overflow_we%0d: we=%b, required 0", k, bus.write_enable);
      end
      tick();
      checks++;
      if (bus.write_pointer !== 7'b1100000 || bus.overflow_error !== 1'b1 || bus.full !== 1'b1) begin
        fails++;
        $display("FAIL overflow_hold%0d: ptr=%b ovf=%b full=%b, required 1100000 1 1",
                 k, bus.write_pointer, bus.overflow_error, bus.full);
      end
    end
    bus.write_request = 1'b0;
  endtask

  task automatic test_drain();
    bus.sync_read_pointer = 7'b0000001;
    tick();
    checks++;
    if (bus.full !== 1'b0 || bus.write_level !== 7'd63 || bus.almost_full !== 1'b1 ||
        bus.overflow_error !== 1'b1) begin
      fails++;
      $display("FAIL drain_one: full=%b lvl=%0d af=%b ovf=%b, required 0 63 1 1",
               bus.full, bus.write_level, bus.almost_full, bus.overflow_error);
    end
    bus.sync_read_pointer = 7'b0000111;
    tick();
    checks++;
    if (bus.write_level !== 7'd59 || bus.almost_full !== 1'b0 || bus.full !== 1'b0) begin
      fails++;
      $display("FAIL drain_five: lvl=%0d af=%b full=%b, required 59 0 0",
               bus.write_level, bus.almost_full, bus.full);
    end
  endtask

  task automatic test_wrap();
    logic seen_top;
    logic seen_wrap;
    seen_top  = 1'b0;
    seen_wrap = 1'b0;
    wcount    = 7'd64;
    bus.write_request = 1'b1;
    for (int k = 0; k < 200; k++) begin
      bus.sync_read_pointer = g(wcount - 7'd1);
      tick();
      wcount = wcount + 7'd1;
      if (bus.write_pointer === 7'b1000000) seen_top = 1'b1;
      if (seen_top && bus.write_pointer === 7'b0000000) seen_wrap = 1'b1;
      checks++;
      if (bus.write_level !== 7'd2 || bus.full !== 1'b0 || bus.write_pointer !== g(wcount)) begin
        fails++;
        $display("FAIL wrap_step%0d: lvl=%0d full=%b ptr=%b, required 2 0 %b",
                 k, bus.write_level, bus.full, bus.write_pointer, g(wcount));
      end
    end
    checks++;
    if (seen_wrap !== 1'b1) begin
      fails++;
      $display("FAIL wrap_seen: observed=%b, required 1", seen_wrap);
    end
    bus.write_request = 1'b0;
  endtask

  task automatic test_simultaneous();
    bus.sync_read_pointer = g(wcount - 7'd63);
    tick();
    checks++;
    if (bus.write_level !== 7'd63 || bus.full !== 1'b0) begin
      fails++;
      $display("FAIL sim_setup: lvl=%0d full=%b, required 63 0", bus.write_level, bus.full);
    end
    bus.write_request     = 1'b1;
    bus.sync_read_pointer = g(wcount - 7'd62);
    #1;
    checks++;
    if (bus.write_enable !== 1'b1) begin
      fails++;
      $display("FAIL sim_we: we=%b, required 1", bus.write_enable);
    end
    tick();
    checks++;
    if (bus.write_level !== 7'd63 || bus.full !== 1'b0 || bus.write_pointer !== g(wcount + 7'd1)) begin
      fails++;
      $display("FAIL sim_result: lvl=%0d full=%b ptr=%b, required 63 0 %b",
               bus.write_level, bus.full, bus.write_pointer, g(wcount + 7'd1));
    end
    bus.write_request = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
